// File: rtl/stoch_to_bin.sv
// Stochastic-to-binary converter: counts ones over a 2^WINDOW_LOG2-sample
// window, scales and saturates to WIDTH bits, hands off on valid/ready.
module stoch_to_bin #(
    parameter int WIDTH       = 8,
    parameter int WINDOW_LOG2 = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cont,
    input  logic             st_in,
    input  logic             st_valid,
    output logic             busy,
    output logic [WIDTH-1:0] bin_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun
);

    localparam int SHIFT = WINDOW_LOG2 - WIDTH;

    generate
        if (WINDOW_LOG2 < WIDTH) begin : g_bad_window
            $error("stoch_to_bin: WINDOW_LOG2 must be >= WIDTH");
        end
    endgenerate

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [WINDOW_LOG2-1:0] sample_cnt_q, sample_cnt_d;
    logic [WINDOW_LOG2:0]   ones_cnt_q, ones_cnt_d;
    logic [WIDTH-1:0]       bin_q, bin_d;
    logic                   out_valid_q, out_valid_d;
    logic                   overrun_q, overrun_d;

    logic                   sample_acc;
    logic                   win_end;
    logic [WINDOW_LOG2:0]   ones_total;
    logic [WINDOW_LOG2:0]   scaled;
    logic [WIDTH-1:0]       result;
    logic                   load;
    logic                   drop;

    // The final sample of the window is folded in combinationally so the
    // result is ready on the same edge that accepts it.
    always_comb begin
        sample_acc = (state_q == COUNT) && st_valid;
        win_end    = sample_acc && (sample_cnt_q == '1);
        ones_total = ones_cnt_q + (WINDOW_LOG2+1)'(st_in);
        scaled     = ones_total >> SHIFT;
        result     = scaled[WIDTH] ? '1 : scaled[WIDTH-1:0];
        load       = win_end && (!out_valid_q || out_ready);
        drop       = win_end && out_valid_q && !out_ready;
    end

    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        ones_cnt_d   = ones_cnt_q;
        bin_d        = bin_q;
        out_valid_d  = out_valid_q;
        overrun_d    = overrun_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = COUNT;
                    sample_cnt_d = '0;
                    ones_cnt_d   = '0;
                    overrun_d    = 1'b0;
                end
            end
            COUNT: begin
                if (win_end) begin
                    sample_cnt_d = '0;
                    ones_cnt_d   = '0;
                    state_d      = cont ? COUNT : IDLE;
                end else if (sample_acc) begin
                    sample_cnt_d = sample_cnt_q + WINDOW_LOG2'(1);
                    ones_cnt_d   = ones_total;
                end
            end
            default: state_d = IDLE;
        endcase

        // A load in the same cycle as a consume keeps valid high.
        if (load) begin
            bin_d       = result;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (drop) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sample_cnt_q <= '0;
            ones_cnt_q   <= '0;
            bin_q        <= '0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            ones_cnt_q   <= ones_cnt_d;
            bin_q        <= bin_d;
            out_valid_q  <= out_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign busy      = (state_q == COUNT);
    assign bin_out   = bin_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

endmodule
